// File: rtl/mod_updn_cntr.sv
// Mod-n up/down counter with synchronous load, terminal-count pulse and saturating wrap tally.
// Latency: one cycle from any input to z/tc/wraps; all outputs registered.
// Backpressure: none; the counter steps on every enabled cycle. MOD_CNTR_SAT_EN selects boundary-hold mode.
module mod_updn_cntr #(
    parameter int n  = 32,
    parameter int WC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 ld,
    input  logic [$clog2(n)-1:0] d,
    output logic [$clog2(n)-1:0] z,
    output logic                 tc,
    output logic [WC-1:0]        wraps
);

    localparam int W = $clog2(n);
    localparam logic [W-1:0] MAXV = W'(n - 1);

    logic [W-1:0] z_nxt;
    logic [W-1:0] z_inc;
    logic [W-1:0] z_dec;
    logic         tc_nxt;

    assign z_inc = z + W'(1);
    assign z_dec = z - W'(1);

    always_comb begin
        z_nxt  = z;
        tc_nxt = 1'b0;
        if (ld) begin
            // d can exceed n-1 only when n is not a power of two
            z_nxt = (d > MAXV) ? MAXV : d;
        end else if (en) begin
            if (up_dn) begin
                if (z == MAXV) begin
`ifdef MOD_CNTR_SAT_EN
                    z_nxt  = MAXV;
`else
                    z_nxt  = '0;
                    tc_nxt = 1'b1;
`endif
                end else begin
                    z_nxt = z_inc;
`ifdef MOD_CNTR_SAT_EN
                    tc_nxt = (z_inc == MAXV);
`endif
                end
            end else begin
                if (z == '0) begin
`ifdef MOD_CNTR_SAT_EN
                    z_nxt  = '0;
`else
                    z_nxt  = MAXV;
                    tc_nxt = 1'b1;
`endif
                end else begin
                    z_nxt = z_dec;
`ifdef MOD_CNTR_SAT_EN
                    tc_nxt = (z_dec == '0);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z     <= '0;
            tc    <= 1'b0;
            wraps <= '0;
        end else begin
            z  <= z_nxt;
            tc <= tc_nxt;
            if (ld) begin
                wraps <= '0;
            end else if (tc_nxt && (wraps != '1)) begin
                wraps <= wraps + WC'(1);
            end
        end
    end

endmodule

// File: tb/tb_mod_updn_cntr.sv
// Drives n=32, n=10 and n=2 (WC=2) counters in lockstep against an arithmetic reference model.
module tb_mod_updn_cntr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, en = 1'b0, up_dn = 1'b0, ld = 1'b0;
    logic [4:0] d32 = '0;
    logic [3:0] d10 = '0;
    logic [0:0] d2  = '0;
    logic [4:0] z32;
    logic [3:0] z10;
    logic [0:0] z2;
    logic       tc32, tc10, tc2;
    logic [7:0] w32, w10;
    logic [1:0] w2;

    mod_updn_cntr #(.n(32), .WC(8)) u32 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .ld(ld),
                                        .d(d32), .z(z32), .tc(tc32), .wraps(w32));
    mod_updn_cntr #(.n(10), .WC(8)) u10 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .ld(ld),
                                        .d(d10), .z(z10), .tc(tc10), .wraps(w10));
    mod_updn_cntr #(.n(2), .WC(2))  u2  (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .ld(ld),
                                        .d(d2), .z(z2), .tc(tc2), .wraps(w2));

    int nn[3]   = '{32, 10, 2};
    int wd[3]   = '{5, 4, 1};
    int wmax[3] = '{255, 255, 3};
    int mz[3]   = '{0, 0, 0};
    int mt[3]   = '{0, 0, 0};
    int mw[3]   = '{0, 0, 0};

    logic [31:0] oz[3], ot[3], ow[3];
    always_comb begin
        oz[0] = 32'(z32);  ot[0] = 32'(tc32); ow[0] = 32'(w32);
        oz[1] = 32'(z10);  ot[1] = 32'(tc10); ow[1] = 32'(w10);
        oz[2] = 32'(z2);   ot[2] = 32'(tc2);  ow[2] = 32'(w2);
    end

    int nchk  = 0;
    int npass = 0;

    // Apply one cycle of stimulus, advance the reference model, settle past the edge.
    task automatic step(input logic r, input logic e, input logic u, input logic l, input int dv);
        int dval, nz, t;
        rst = r; en = e; up_dn = u; ld = l;
        d32 = dv[4:0]; d10 = dv[3:0]; d2 = dv[0:0];
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            dval = dv % (1 << wd[i]);
            if (r) begin
                mz[i] = 0; mt[i] = 0; mw[i] = 0;
            end else if (l) begin
                mz[i] = (dval < nn[i]) ? dval : nn[i] - 1;
                mt[i] = 0; mw[i] = 0;
            end else if (e) begin
`ifdef MOD_CNTR_SAT_EN
                if (u) nz = (mz[i] + 1 > nn[i] - 1) ? nn[i] - 1 : mz[i] + 1;
                else   nz = (mz[i] - 1 < 0) ? 0 : mz[i] - 1;
                t = (nz != mz[i]) && (nz == (u ? nn[i] - 1 : 0)) ? 1 : 0;
`else
                if (u) nz = (mz[i] + 1) % nn[i];
                else   nz = (mz[i] + nn[i] - 1) % nn[i];
                t = u ? ((mz[i] + 1 >= nn[i]) ? 1 : 0) : ((mz[i] - 1 < 0) ? 1 : 0);
`endif
                mz[i] = nz;
                mt[i] = t;
                if (t == 1) mw[i] = (mw[i] + 1 > wmax[i]) ? wmax[i] : mw[i] + 1;
            end else begin
                mt[i] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 7);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (oz[i] !== 0 || ot[i] !== 0 || ow[i] !== 0)
                $display("FAIL reset n=%0d: z/tc/wraps got %0d/%0d/%0d exp 0/0/0", nn[i], oz[i], ot[i], ow[i]);
            else npass++;
        end
    endtask

    task automatic test_count_up();
        step(1, 0, 0, 0, 0);
        for (int c = 1; c <= 40; c++) begin
            step(0, 1, 1, 0, 0);
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (oz[i] !== mz[i] || ot[i] !== mt[i] || ow[i] !== mw[i])
                    $display("FAIL count_up n=%0d cyc %0d: z/tc/wraps got %0d/%0d/%0d exp %0d/%0d/%0d",
                             nn[i], c, oz[i], ot[i], ow[i], mz[i], mt[i], mw[i]);
                else npass++;
            end
`ifndef MOD_CNTR_SAT_EN
            if (c == 32) begin
                nchk++;
                if (z32 !== 5'd0 || tc32 !== 1'b1 || w32 !== 8'd1)
                    $display("FAIL up32_wrap: z/tc/wraps got %0d/%0d/%0d exp 0/1/1", z32, tc32, w32);
                else npass++;
            end
            if (c == 6) begin
                nchk++;
                if (z2 !== 1'b0 || tc2 !== 1'b1 || w2 !== 2'd3)
                    $display("FAIL n2_sat: z/tc/wraps got %0d/%0d/%0d exp 0/1/3", z2, tc2, w2);
                else npass++;
            end
`else
            if (c == 9 || c == 12) begin
                nchk++;
                if (z10 !== 4'd9 || tc10 !== (c == 9) || w10 !== 8'd1)
                    $display("FAIL sat10 cyc %0d: z/tc/wraps got %0d/%0d/%0d exp 9/%0d/1",
                             c, z10, tc10, w10, (c == 9));
                else npass++;
            end
`endif
        end
    endtask

    task automatic test_count_down();
        step(1, 0, 0, 0, 0);
        for (int c = 1; c <= 11; c++) begin
            step(0, 1, 0, 0, 0);
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (oz[i] !== mz[i] || ot[i] !== mt[i] || ow[i] !== mw[i])
                    $display("FAIL count_down n=%0d cyc %0d: z/tc/wraps got %0d/%0d/%0d exp %0d/%0d/%0d",
                             nn[i], c, oz[i], ot[i], ow[i], mz[i], mt[i], mw[i]);
                else npass++;
            end
`ifndef MOD_CNTR_SAT_EN
            if (c == 1 || c == 11) begin
                nchk++;
                if (z10 !== 4'd9 || tc10 !== 1'b1 || w10 !== ((c == 1) ? 8'd1 : 8'd2))
                    $display("FAIL down10 cyc %0d: z/tc/wraps got %0d/%0d/%0d exp 9/1/%0d",
                             c, z10, tc10, w10, (c == 1) ? 1 : 2);
                else npass++;
            end
`endif
        end
    endtask

    task automatic test_load();
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 13);
        nchk++;
        if (z10 !== 4'd9 || tc10 !== 1'b0 || w10 !== 8'd0 || z32 !== 5'd13)
            $display("FAIL load_clamp: z10/tc10/w10/z32 got %0d/%0d/%0d/%0d exp 9/0/0/13", z10, tc10, w10, z32);
        else npass++;
        step(0, 1, 1, 1, 4);
        nchk++;
        if (z10 !== 4'd4 || z32 !== 5'd4 || tc10 !== 1'b0)
            $display("FAIL load_over_en: z10/z32/tc10 got %0d/%0d/%0d exp 4/4/0", z10, z32, tc10);
        else npass++;
        step(0, 0, 1, 0, 0);
        nchk++;
        if (z10 !== 4'd4 || tc10 !== 1'b0 || z32 !== 5'd4)
            $display("FAIL hold: z10/tc10/z32 got %0d/%0d/%0d exp 4/0/4", z10, tc10, z32);
        else npass++;
    endtask

    task automatic test_reset_priority();
        step(0, 0, 0, 1, 5);
        step(1, 1, 1, 1, 7);
        nchk++;
        if (z10 !== 4'd0 || tc10 !== 1'b0 || w10 !== 8'd0)
            $display("FAIL rst_priority: z/tc/wraps got %0d/%0d/%0d exp 0/0/0", z10, tc10, w10);
        else npass++;
        step(0, 1, 0, 0, 0);
        nchk++;
        if (oz[1] !== mz[1] || ot[1] !== mt[1] || ow[1] !== mw[1])
            $display("FAIL rev_down: z/tc/wraps got %0d/%0d/%0d exp %0d/%0d/%0d",
                     oz[1], ot[1], ow[1], mz[1], mt[1], mw[1]);
        else npass++;
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        nchk++;
        if (z10 !== 4'd1 || tc10 !== 1'b0)
            $display("FAIL rev_up: z/tc got %0d/%0d exp 1/0", z10, tc10);
        else npass++;
    endtask

    task automatic test_random();
        logic r, e, u, l;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 11) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 3) != 0) ? (c[6] == 1'b0) : 1'($urandom_range(0, 1));
            step(r, e, u, l, int'($urandom_range(0, 31)));
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (oz[i] !== mz[i] || ot[i] !== mt[i] || ow[i] !== mw[i])
                    $display("FAIL random n=%0d cyc %0d: z/tc/wraps got %0d/%0d/%0d exp %0d/%0d/%0d",
                             nn[i], c, oz[i], ot[i], ow[i], mz[i], mt[i], mw[i]);
                else npass++;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
